// File: rtl/password_code_transmitter_if.sv
// ---------------------------------------------------------------------------
// password_code_transmitter_if
//
// Purpose: bundles the keypad-side request/result handshake and the serial
// link to the door lock for password_code_transmitter.
//
// Parameters (must match the transmitter instance):
//   CODE_W     code length in bits
//   MAX_RETRY  retries after the first attempt (sizes retries_used)
//
// Signals:
//   code_in       code to send, captured on accept
//   start_valid   request to send code_in
//   start_ready   transmitter idle; accept = start_valid && start_ready
//   dout          registered serial data towards the lock's din
//   unlock_in     lock's unlock output
//   busy          operation in progress
//   done          one-cycle pulse when an operation finishes
//   success       lock opened (held until next accept)
//   fail          retries exhausted or aborted (held until next accept)
//   retries_used  retries consumed by the current/last operation
//   abort         only when PWTX_ABORT_EN is defined: cancel operation
//
// Modports:
//   slave   the transmitter's view
//   master  the environment's view (controller plus lock)
// ---------------------------------------------------------------------------
interface password_code_transmitter_if #(
  parameter int CODE_W    = 4,
  parameter int MAX_RETRY = 2
);

  // A zero-retry configuration still needs a one-bit counter port.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [CODE_W-1:0] code_in;
  logic              start_valid;
  logic              start_ready;
  logic              dout;
  logic              unlock_in;
  logic              busy;
  logic              done;
  logic              success;
  logic              fail;
  logic [RW-1:0]     retries_used;
`ifdef PWTX_ABORT_EN
  logic              abort;
`endif

`ifdef PWTX_ABORT_EN
  modport slave (
    input  code_in, start_valid, unlock_in, abort,
    output start_ready, dout, busy, done, success, fail, retries_used
  );

  modport master (
    output code_in, start_valid, unlock_in, abort,
    input  start_ready, dout, busy, done, success, fail, retries_used
  );
`else
  modport slave (
    input  code_in, start_valid, unlock_in,
    output start_ready, dout, busy, done, success, fail, retries_used
  );

  modport master (
    output code_in, start_valid, unlock_in,
    input  start_ready, dout, busy, done, success, fail, retries_used
  );
`endif

endinterface

// File: rtl/password_code_transmitter.sv
// ---------------------------------------------------------------------------
// password_code_transmitter
//
// Purpose: initiator side of the serial password lock link. Captures a
// CODE_W-bit code, shifts it out MSB first on dout (one bit per clk), then
// watches unlock_in for RESP_WAIT cycles. On timeout it idles the line for
// GAP_CYCLES cycles and resends the latched code, up to MAX_RETRY retries,
// before reporting fail.
//
// Ports:
//   clk       clock
//   reset_n   asynchronous active-low reset
//   bus       password_code_transmitter_if.slave (request handshake,
//             serial line, lock response, result flags)
//
// Optional feature: define PWTX_ABORT_EN to add bus.abort, which cancels an
// operation in SEND/WAIT/GAP and finishes it with fail next cycle.
// ---------------------------------------------------------------------------
module password_code_transmitter #(
  parameter int CODE_W     = 4,
  parameter int RESP_WAIT  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_RETRY  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  password_code_transmitter_if.slave   bus
);

  localparam int BIT_W   = $clog2(CODE_W + 1);
  localparam int CNT_MAX = (RESP_WAIT > GAP_CYCLES) ? RESP_WAIT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CODE_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_WAIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t            state, state_next;
  logic [CODE_W-1:0] code_q, code_next;
  logic [CODE_W-1:0] shift_q, shift_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [RW-1:0]     retries_q, retries_next;
  logic              dout_q, dout_next;
  logic              success_q, success_next;
  logic              fail_q, fail_next;
  logic              abort_hit;

  // Every output-facing flag is registered so dout changes cleanly on clk
  // and is forced low the instant reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      code_q    <= '0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
      retries_q <= '0;
      dout_q    <= 1'b0;
      success_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_next;
      code_q    <= code_next;
      shift_q   <= shift_next;
      bit_cnt   <= bit_next;
      cnt       <= cnt_next;
      retries_q <= retries_next;
      dout_q    <= dout_next;
      success_q <= success_next;
      fail_q    <= fail_next;
    end
  end

  // Next-state logic. dout is computed one cycle ahead: entering SEND loads
  // the MSB so the first bit is on the line the cycle after accept, and the
  // rest of the word is walked out of shift_q.
  always_comb begin
    state_next   = state;
    code_next    = code_q;
    shift_next   = shift_q;
    bit_next     = bit_cnt;
    cnt_next     = cnt;
    retries_next = retries_q;
    dout_next    = 1'b0;
    success_next = success_q;
    fail_next    = fail_q;
    abort_hit    = 1'b0;

`ifdef PWTX_ABORT_EN
    abort_hit = bus.abort &&
                ((state == ST_SEND) || (state == ST_WAIT) || (state == ST_GAP));
`endif

    case (state)
      ST_IDLE: begin
        if (bus.start_valid) begin
          code_next    = bus.code_in;
          shift_next   = bus.code_in << 1;
          dout_next    = bus.code_in[CODE_W-1];
          bit_next     = '0;
          retries_next = '0;
          success_next = 1'b0;
          fail_next    = 1'b0;
          state_next   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (bit_cnt >= LAST_BIT) begin
          cnt_next   = '0;
          state_next = ST_WAIT;
        end else begin
          dout_next  = shift_q[CODE_W-1];
          shift_next = shift_q << 1;
          bit_next   = bit_cnt + BIT_W'(1);
        end
      end

      // unlock_in is tested before the timeout so a response on the last
      // wait cycle still counts as success.
      ST_WAIT: begin
        if (bus.unlock_in) begin
          success_next = 1'b1;
          state_next   = ST_DONE;
        end else if (cnt >= WAIT_LAST) begin
          if (retries_q >= RETRY_MAX) begin
            fail_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            retries_next = retries_q + RW'(1);
            cnt_next     = '0;
            state_next   = ST_GAP;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      // The zero gap lets the lock's detector flush before the resend,
      // which always uses the latched code rather than code_in.
      ST_GAP: begin
        if (cnt >= GAP_LAST) begin
          dout_next  = code_q[CODE_W-1];
          shift_next = code_q << 1;
          bit_next   = '0;
          state_next = ST_SEND;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the state decided, including an unlock seen
    // in the same cycle; retries_used keeps its current value.
    if (abort_hit) begin
      dout_next    = 1'b0;
      success_next = 1'b0;
      fail_next    = 1'b1;
      retries_next = retries_q;
      state_next   = ST_DONE;
    end
  end

  assign bus.start_ready  = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.dout         = dout_q;
  assign bus.success      = success_q;
  assign bus.fail         = fail_q;
  assign bus.retries_used = retries_q;

endmodule
